// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle fetch/decode/mem/exec/pc-update controller for a 16-bit accumulator datapath.
// Define CTRL_WRAP_TRAP_EN to trap (sticky ERR) on PC overflow/underflow instead of wrapping silently.
module ctrl_fsm #(
    parameter int BITS = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            hold_ni,
    input  logic [BITS-1:0] instr_i,
    output logic            imem_req_o,
    input  logic            imem_ready_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    input  logic            dmem_ready_i,
    output logic [7:0]      dmem_addr_o,
    input  logic [1:0]      zn_i,
    input  logic            pc_of_i,
    input  logic            pc_uf_i,
    output logic [4:0]      opcode_o,
    output logic [10:0]     operand_o,
    output logic            sel_jmp_o,
    output logic            sel_branch_o,
    output logic            sel_op_mem_o,
    output logic            en_pc_o,
    output logic            en_in_o,
    output logic            en_acc_o,
    output logic            en_indr_o,
    output logic [2:0]      state_o,
    output logic            halt_o,
    output logic            err_o
);
    typedef enum logic [2:0] {
        FETCH  = 3'b000,
        DECODE = 3'b001,
        MEM    = 3'b010,
        EXEC   = 3'b011,
        PCUPD  = 3'b100,
        HLT    = 3'b101,
        TRAP   = 3'b110
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  opcode_q, opcode_d;
    logic [10:0] operand_q, operand_d;
    logic        imem_req, en_pc, en_in, en_acc, en_indr, wrap;
    logic        is_nop, is_alu_mem, is_alu_imm, is_indr_add, is_jmp, is_bz, is_bn, is_ldindr, is_store, is_halt;
    logic        taken;

    assign is_nop      = opcode_q == 5'b00000;
    assign is_alu_mem  = !opcode_q[4] && !is_nop;
    assign is_alu_imm  = opcode_q[4:3] == 2'b10;
    assign is_indr_add = opcode_q[4:1] == 4'b1100;
    assign is_jmp      = opcode_q == 5'b11010;
    assign is_bz       = opcode_q == 5'b11011;
    assign is_bn       = opcode_q == 5'b11100;
    assign is_ldindr   = opcode_q == 5'b11101;
    assign is_store    = opcode_q == 5'b11110;
    assign is_halt     = opcode_q == 5'b11111;
    assign taken       = (is_bz && zn_i == 2'b10) || (is_bn && zn_i == 2'b01);

`ifdef CTRL_WRAP_TRAP_EN
    assign wrap  = pc_of_i || pc_uf_i;
    assign err_o = state_q == TRAP;
`else
    logic unused_wrap_flags;
    assign unused_wrap_flags = pc_of_i ^ pc_uf_i;
    assign wrap  = 1'b0;
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= FETCH;
            opcode_q  <= '0;
            operand_q <= '0;
        end else if (hold_ni) begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        operand_d    = operand_q;
        imem_req     = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        sel_jmp_o    = 1'b1;
        sel_branch_o = 1'b1;
        sel_op_mem_o = 1'b0;
        en_pc        = 1'b0;
        en_in        = 1'b0;
        en_acc       = 1'b0;
        en_indr      = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready_i) begin
                    state_d   = DECODE;
                    opcode_d  = instr_i[BITS-1 -: 5];
                    operand_d = instr_i[10:0];
                end
            end
            DECODE: begin
                en_in        = is_alu_imm;
                sel_op_mem_o = is_alu_imm;
                state_d      = (is_alu_mem || is_ldindr || is_store) ? MEM :
                               (is_alu_imm || is_indr_add)           ? EXEC :
                               is_halt                                ? HLT : PCUPD;
            end
            MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = is_store;
                if (dmem_ready_i) begin
                    en_in   = is_alu_mem;
                    en_indr = is_ldindr;
                    state_d = is_alu_mem ? EXEC : PCUPD;
                end
            end
            EXEC: begin
                en_acc  = is_alu_mem || is_alu_imm;
                en_indr = is_indr_add;
                state_d = PCUPD;
            end
            PCUPD: begin
                en_pc        = !wrap;
                sel_jmp_o    = wrap || !is_jmp;
                sel_branch_o = wrap || !taken;
                state_d      = wrap ? TRAP : FETCH;
            end
            HLT:     state_d = HLT;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // Hold freezes progress: enables are squashed but pending requests stay visible.
    assign imem_req_o  = imem_req && rst_ni;
    assign en_pc_o     = en_pc && hold_ni;
    assign en_in_o     = en_in && hold_ni;
    assign en_acc_o    = en_acc && hold_ni;
    assign en_indr_o   = en_indr && hold_ni;
    assign dmem_addr_o = operand_q[7:0];
    assign opcode_o    = opcode_q;
    assign operand_o   = operand_q;
    assign state_o     = state_q;
    assign halt_o      = state_q == HLT;
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: random instruction/handshake/hold/reset stimulus checked cycle by cycle against a
// per-instruction phase-plan model derived from the instruction class latency table.
module tb_ctrl_fsm;
    localparam int S_F = 0, S_D = 1, S_M = 2, S_E = 3, S_P = 4, S_H = 5, S_T = 6;
    localparam int C_NOP = 0, C_AM = 1, C_AI = 2, C_IA = 3, C_JMP = 4, C_BZ = 5, C_BN = 6,
                   C_LDI = 7, C_ST = 8, C_HLT = 9;
`ifdef CTRL_WRAP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, hold_n = 1'b1;
    logic [15:0] instr = '0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0, pc_of = 1'b0, pc_uf = 1'b0;
    logic [1:0]  zn = '0;
    logic        imem_req, dmem_req, dmem_we, sel_jmp, sel_branch, sel_op_mem;
    logic        en_pc, en_in, en_acc, en_indr, halt, err;
    logic [7:0]  dmem_addr;
    logic [4:0]  opcode;
    logic [10:0] operand;
    logic [2:0]  state;

    int          n_tests = 0, n_fail = 0;
    int          plan[$];
    logic [4:0]  m_op = '0;
    logic [10:0] m_opr = '0;

    always #5 clk = ~clk;

    ctrl_fsm dut (
        .clk_i(clk), .rst_ni(rst_n), .hold_ni(hold_n), .instr_i(instr),
        .imem_req_o(imem_req), .imem_ready_i(imem_ready),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_ready_i(dmem_ready),
        .dmem_addr_o(dmem_addr), .zn_i(zn), .pc_of_i(pc_of), .pc_uf_i(pc_uf),
        .opcode_o(opcode), .operand_o(operand),
        .sel_jmp_o(sel_jmp), .sel_branch_o(sel_branch), .sel_op_mem_o(sel_op_mem),
        .en_pc_o(en_pc), .en_in_o(en_in), .en_acc_o(en_acc), .en_indr_o(en_indr),
        .state_o(state), .halt_o(halt), .err_o(err)
    );

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h (op %0h)", tag, $time, act, exp, m_op);
        end
    endtask

    function automatic int cls_of(input logic [4:0] op);
        return op == 0 ? C_NOP : op < 16 ? C_AM : op < 24 ? C_AI : op < 26 ? C_IA : int'(op) - 22;
    endfunction

    task automatic compare();
        int e, c;
        bit trap, pc_act, tk;
        e      = plan.size() == 0 ? S_F : plan[0];
        c      = cls_of(m_op);
        trap   = TRAP_EN && (pc_of || pc_uf);
        pc_act = e == S_P && !trap;
        tk     = (c == C_BZ && zn == 2'b10) || (c == C_BN && zn == 2'b01);
        chk("state", 16'(state), 16'(e));
        chk("opcode", 16'(opcode), 16'(m_op));
        chk("operand", 16'(operand), 16'(m_opr));
        chk("dmem_addr", 16'(dmem_addr), 16'(m_opr[7:0]));
        chk("imem_req", 16'(imem_req), 16'(e == S_F && rst_n));
        chk("dmem_req", 16'(dmem_req), 16'(e == S_M));
        chk("dmem_we", 16'(dmem_we), 16'(e == S_M && c == C_ST));
        chk("sel_op_mem", 16'(sel_op_mem), 16'(e == S_D && c == C_AI));
        chk("en_in", 16'(en_in), 16'(hold_n && ((e == S_D && c == C_AI) || (e == S_M && dmem_ready && c == C_AM))));
        chk("en_indr", 16'(en_indr), 16'(hold_n && ((e == S_M && dmem_ready && c == C_LDI) || (e == S_E && c == C_IA))));
        chk("en_acc", 16'(en_acc), 16'(hold_n && e == S_E && (c == C_AM || c == C_AI)));
        chk("en_pc", 16'(en_pc), 16'(hold_n && pc_act));
        chk("sel_jmp", 16'(sel_jmp), 16'(!(pc_act && c == C_JMP)));
        chk("sel_branch", 16'(sel_branch), 16'(!(pc_act && tk)));
        chk("halt", 16'(halt), 16'(e == S_H));
        chk("err", 16'(err), 16'(e == S_T));
    endtask

    task automatic advance();
        int c;
        if (hold_n) begin
            if (plan.size() == 0) begin
                if (imem_ready) begin
                    m_op  = instr[15:11];
                    m_opr = instr[10:0];
                    c     = cls_of(m_op);
                    plan.push_back(S_D);
                    if (c == C_AM || c == C_LDI || c == C_ST) plan.push_back(S_M);
                    if (c == C_AM || c == C_AI || c == C_IA) plan.push_back(S_E);
                    plan.push_back(c == C_HLT ? S_H : S_P);
                end
            end else if (plan[0] == S_H || plan[0] == S_T || (plan[0] == S_M && !dmem_ready)) begin
            end else if (plan[0] == S_P && TRAP_EN && (pc_of || pc_uf)) begin
                plan.delete();
                plan.push_back(S_T);
            end else begin
                void'(plan.pop_front());
            end
        end
    endtask

    task automatic step(input bit rst_v);
        @(negedge clk);
        rst_n      = rst_v;
        hold_n     = ($urandom % 5) != 0;
        instr      = 16'($urandom);
        imem_ready = ($urandom % 3) != 0;
        dmem_ready = ($urandom % 3) != 0;
        zn         = 2'($urandom);
        pc_of      = ($urandom % 10) == 0;
        pc_uf      = ($urandom % 10) == 0;
        if (!rst_n) begin
            plan.delete();
            m_op  = '0;
            m_opr = '0;
        end
        #1 compare();
        if (rst_n) advance();
    endtask

    initial begin
        for (int s = 0; s < 25; s++) begin
            repeat (2) step(1'b0);
            repeat (120) step(1'b1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameter: BITS, 16, instruction/data word width; OPCODE = INSTR[15:11], OPERAND = INSTR[10:0].
REQ-002 CLOCK  in  1  sole clock; all state changes on rising edge.
REQ-003 RESETn  in  1  asynchronous, active-low reset.
REQ-004 HOLDn  in  1  low = freeze state; all EN_* outputs forced 0.
REQ-005 INSTR  in  BITS  instruction word from instruction memory, valid with IMEM_READY.
REQ-006 IMEM_REQ / IMEM_READY  out/in  1/1  instruction fetch handshake.
REQ-007 DMEM_REQ / DMEM_WE / DMEM_READY  out/out/in  1/1/1  data memory handshake; DMEM_WE=1 write.
REQ-008 DMEM_ADDR  out  8  = OPERAND[7:0].
REQ-009 ZN  in  2  datapath flags: 10 zero, 01 negative.
REQ-010 PC_OF, PC_UF  in  1  datapath PC overflow/underflow.
REQ-011 OPCODE / OPERAND  out  5/11  registered instruction fields.
REQ-012 SEL_JMP, SEL_BRANCH, SEL_OP_MEM, EN_PC, EN_IN, EN_ACC, EN_INDR  out  1 each  datapath controls.
REQ-013 STATE  out  3  current state code; HALT  out  1; ERR  out  1.

Function
REQ-014 States: FETCH 000, DECODE 001, MEM 010, EXEC 011, PCUPD 100, HLT 101, TRAP 110; other codes shall go to FETCH.
REQ-015 Opcode classes: 00000 NOP; 00001-01111 ALU-mem; 10000-10111 ALU-imm; 11000/11001 INDR-add; 11010 JMP; 11011 BZ; 11100 BN; 11101 LDINDR; 11110 STORE; 11111 HALT.
REQ-016 FETCH: IMEM_REQ=1 until IMEM_READY sampled 1; that edge latches INSTR into OPCODE/OPERAND, next state DECODE.
REQ-017 DECODE: ALU-mem/LDINDR/STORE -> MEM; ALU-imm -> EXEC with EN_IN=1, SEL_OP_MEM=1 this cycle; INDR-add -> EXEC; NOP/JMP/BZ/BN -> PCUPD; HALT -> HLT.
REQ-018 MEM: DMEM_REQ=1, DMEM_WE=1 only for STORE, held until DMEM_READY=1; in the READY cycle ALU-mem asserts EN_IN=1, SEL_OP_MEM=0, -> EXEC; LDINDR asserts EN_INDR=1, -> PCUPD; STORE -> PCUPD.
REQ-019 EXEC: EN_ACC=1 for ALU classes, EN_INDR=1 for INDR-add; next PCUPD.
REQ-020 PCUPD: EN_PC=1; JMP: SEL_JMP=0; BZ taken iff ZN==10, BN taken iff ZN==01: SEL_JMP=1, SEL_BRANCH=0; otherwise SEL_JMP=1, SEL_BRANCH=1; next FETCH.
REQ-021 Outside the listed cycles every EN_*, IMEM_REQ, DMEM_REQ, DMEM_WE = 0; SEL_JMP=1, SEL_BRANCH=1, SEL_OP_MEM=0 as defaults.
REQ-022 Zero-wait latency per instruction: NOP/JMP/branch 3 cycles, ALU-imm/INDR-add 4, ALU-mem/LDINDR/STORE 4-5 (ALU-mem 5).
REQ-023 HOLDn low: state, OPCODE, OPERAND held; pending REQ held asserted; a READY arriving while HOLDn low shall be ignored.
REQ-024 HLT: HALT=1, all enables 0, no exit except reset.
REQ-025 ZN sampled only in PCUPD; value changes in other states shall not affect the decision.

Reset
REQ-026 RESETn low: STATE=FETCH, OPCODE=0, OPERAND=0, HALT=0, ERR=0, all EN_*/REQ/WE=0, SEL_JMP=1, SEL_BRANCH=1, SEL_OP_MEM=0.
REQ-027 Reset mid-handshake shall drop REQ immediately; first fetch begins the cycle after RESETn rises.

Configuration
REQ-028 Macro CTRL_WRAP_TRAP_EN defined: in PCUPD, PC_OF or PC_UF =1 suppresses EN_PC, enters TRAP, ERR=1 sticky until reset, all enables 0.
REQ-029 CTRL_WRAP_TRAP_EN undefined: PC_OF/PC_UF ignored, PC wraps silently, TRAP unreachable, ERR tied 0.

Verification
REQ-030 Reset release, INSTR=16'h0000, IMEM_READY=1 -> STATE 000,001,100,000; EN_PC=1 exactly in state 100 with SEL_BRANCH=1.
REQ-031 INSTR=ALU-mem 5'b00011, DMEM_READY after 3 wait cycles -> DMEM_REQ high 4 cycles, EN_IN=1 on READY cycle, EN_ACC=1 next cycle.
REQ-032 BZ with ZN=10 -> PCUPD SEL_JMP=1, SEL_BRANCH=0; repeat with ZN=00 -> SEL_BRANCH=1.
REQ-033 JMP operand 11'h05A -> PCUPD SEL_JMP=0, EN_PC=1; HALT opcode -> HALT=1 held 100 cycles, no REQ.
REQ-034 HOLDn low 5 cycles during MEM with DMEM_READY=1 -> state stays 010, all EN_*=0; resumes on HOLDn high.
REQ-035 CTRL_WRAP_TRAP_EN defined, PC_OF=1 in PCUPD -> EN_PC=0, STATE=110, ERR=1 until RESETn low.
